// File: rtl/contador_minutos_horas_pkg.sv
// Shared clock-stage package: FSM state type, digit limits and a BCD helper.
// Used by contador_minutos_horas (optional 12-hour build via FORMATO_12H_EN).
package relogio_pkg;

  typedef enum logic [0:0] {
    CONTANDO = 1'b0,
    AJUSTE   = 1'b1
  } estado_ajuste_t;

  localparam int MIN_DEZENA_MAX = 5;
  localparam int HORA_MAX_24    = 23;
  localparam int HORA_MAX_12    = 12;
  localparam int MIN_MAX        = MIN_DEZENA_MAX * 10 + 9;

  function automatic logic [7:0] bcd8(input int v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

endpackage

// File: rtl/contador_minutos_horas_if.sv
// Control/display bundle between the minutes/hours stage and its environment.
// The pm signal exists only when FORMATO_12H_EN is defined.
interface contador_minutos_horas_if;
  logic       enable;
  logic       modo_ajuste;
  logic       inc_min;
  logic       inc_hora;
  logic [3:0] min_unidade;
  logic [2:0] min_dezena;
  logic [3:0] hora_unidade;
  logic [1:0] hora_dezena;
  logic       carry_dia;
  logic       ajustando;
`ifdef FORMATO_12H_EN
  logic       pm;

  modport master (
    output enable, modo_ajuste, inc_min, inc_hora,
    input  min_unidade, min_dezena, hora_unidade, hora_dezena,
    input  carry_dia, ajustando, pm
  );
  modport slave (
    input  enable, modo_ajuste, inc_min, inc_hora,
    output min_unidade, min_dezena, hora_unidade, hora_dezena,
    output carry_dia, ajustando, pm
  );
`else
  modport master (
    output enable, modo_ajuste, inc_min, inc_hora,
    input  min_unidade, min_dezena, hora_unidade, hora_dezena,
    input  carry_dia, ajustando
  );
  modport slave (
    input  enable, modo_ajuste, inc_min, inc_hora,
    output min_unidade, min_dezena, hora_unidade, hora_dezena,
    output carry_dia, ajustando
  );
`endif
endinterface

// File: rtl/contador_minutos_horas_bcd_par.sv
// Two-digit BCD counter: steps on inc, wraps from limit back to LOW.
// wrap flags a limit crossing only while carry_en is high.
module contador_bcd_par #(
  parameter int         TW      = 3,
  parameter logic [7:0] LOW     = 8'h00,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          carry_en,
  input  logic [7:0]    limit,
  output logic [3:0]    units,
  output logic [TW-1:0] tens,
  output logic          wrap
);
  logic [3:0]    r_units;
  logic [TW-1:0] r_tens;
  logic          w_at_limit;

  assign w_at_limit = ({{(4-TW){1'b0}}, r_tens} == limit[7:4]) && (r_units == limit[3:0]);
  assign wrap       = inc & carry_en & w_at_limit;
  assign units      = r_units;
  assign tens       = r_tens;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_units <= RST_VAL[3:0];
      r_tens  <= RST_VAL[TW+3:4];
    end else if (inc) begin
      if (w_at_limit) begin
        r_units <= LOW[3:0];
        r_tens  <= LOW[TW+3:4];
      end else if (r_units == 4'd9) begin
        r_units <= 4'd0;
        r_tens  <= r_tens + TW'(1);
      end else begin
        r_units <= r_units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/contador_minutos_horas.sv
// Minutes/hours stage: counts seconds carries, set mode, day-rollover pulse.
// Define FORMATO_12H_EN for 12-hour display (12,01..11) with a pm flag.
module contador_minutos_horas
  import relogio_pkg::*;
(
  input  logic clk,
  input  logic rst,
  contador_minutos_horas_if.slave bus
);
  estado_ajuste_t r_estado;
  logic           r_carry_dia;
  logic           w_contando;
  logic           w_inc_min;
  logic           w_inc_hora;
  logic           w_min_wrap;
  logic           w_hora_wrap;
  logic           w_carry_dia;
  logic [3:0]     w_hora_u;
  logic [1:0]     w_hora_t;

  assign w_contando = (r_estado == CONTANDO);
  // Count mode takes the seconds carry, set mode takes the buttons.
  assign w_inc_min  = w_contando ? bus.enable : bus.inc_min;
  assign w_inc_hora = w_min_wrap | (~w_contando & bus.inc_hora);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado    <= CONTANDO;
      r_carry_dia <= 1'b0;
    end else begin
      r_estado    <= bus.modo_ajuste ? AJUSTE : CONTANDO;
      r_carry_dia <= w_carry_dia;
    end
  end

  contador_bcd_par #(.TW(3), .LOW(8'h00), .RST_VAL(8'h00)) u_min (
    .clk(clk), .rst(rst), .inc(w_inc_min), .carry_en(w_contando),
    .limit(bcd8(MIN_MAX)), .units(bus.min_unidade), .tens(bus.min_dezena),
    .wrap(w_min_wrap)
  );

`ifdef FORMATO_12H_EN
  logic r_pm;
  logic w_hora_onze;

  assign w_hora_onze = (w_hora_t == 2'd1) && (w_hora_u == 4'd1);
  // 11 -> 12 is where the half-day flips; the 11 PM carry ends the day.
  assign w_carry_dia = w_min_wrap & w_hora_onze & r_pm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pm <= 1'b0;
    end else if (w_inc_hora && w_hora_onze) begin
      r_pm <= ~r_pm;
    end else begin
      r_pm <= r_pm;
    end
  end

  assign bus.pm = r_pm;

  contador_bcd_par #(.TW(2), .LOW(8'h01), .RST_VAL(8'h12)) u_hora (
    .clk(clk), .rst(rst), .inc(w_inc_hora), .carry_en(1'b0),
    .limit(bcd8(HORA_MAX_12)), .units(w_hora_u), .tens(w_hora_t),
    .wrap(w_hora_wrap)
  );
`else
  assign w_carry_dia = w_hora_wrap;

  contador_bcd_par #(.TW(2), .LOW(8'h00), .RST_VAL(8'h00)) u_hora (
    .clk(clk), .rst(rst), .inc(w_inc_hora), .carry_en(w_contando),
    .limit(bcd8(HORA_MAX_24)), .units(w_hora_u), .tens(w_hora_t),
    .wrap(w_hora_wrap)
  );
`endif

  assign bus.hora_unidade = w_hora_u;
  assign bus.hora_dezena  = w_hora_t;
  assign bus.carry_dia    = r_carry_dia;
  assign bus.ajustando    = (r_estado == AJUSTE);

endmodule
